// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX fetch stage: instruction width, the special
// NOP/HALT encodings and the fetch FSM state encoding.
package dlx_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/dlx_if_id_reg.sv
// IF/ID pipeline register: holds instruction, its byte address, next address
// and a valid flag. Controls are reset > flush > load > hold.
module dlx_if_id_reg
  import dlx_pkg::*;
#(
  parameter logic [INST_W-1:0] FLUSH_WORD = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       npc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       npc_o,
  output logic              valid_o
);

  logic [INST_W-1:0] inst_q;
  logic [31:0]       pc_q;
  logic [31:0]       npc_q;
  logic              valid_q;

  // Flush keeps pc/npc so the bubble still carries the last known address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= FLUSH_WORD;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= FLUSH_WORD;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      npc_q   <= npc_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: PC register, ROM word index, BOOT/RUN/HALT FSM
// and the IF/ID register. Optional macro FETCH_PERF_CNT_EN adds a 32-bit
// count of captured instructions on fetch_cnt_o (tied to 0 otherwise).
module dlx_fetch_unit #(
  parameter int          ROM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = dlx_pkg::NOP_WORD,
  parameter logic [31:0] HALT_WORD = dlx_pkg::HALT_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic        valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
);

  import dlx_pkg::*;

  localparam int AW = $clog2(ROM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        load, flush;

  // State and PC registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and IF/ID controls; RUN priority is redirect > stall > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i & ~32'd3;
          flush = 1'b1;
        end else if (!stall_i) begin
          load = 1'b1;
          if (rom_data_i == HALT_WORD) state_d = HALT;
          else                         pc_d    = pc_q + 32'd4;
        end
      end
      HALT: flush = !stall_i;
      default: state_d = BOOT;
    endcase
  end

  assign rom_addr_o = {{(32-AW){1'b0}}, pc_q[AW+1:2]};
  assign halted_o   = (state_q == HALT);

  dlx_if_id_reg #(.FLUSH_WORD(NOP_WORD)) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .flush_i (flush),
    .inst_i  (rom_data_i),
    .pc_i    (pc_q),
    .npc_i   (pc_q + 32'd4),
    .inst_o  (inst_o),
    .pc_o    (pc_o),
    .npc_o   (npc_o),
    .valid_o (valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Count every RUN-state capture, HALT_WORD included; wraps naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i)     fetch_cnt_q <= '0;
    else if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_cnt_o = fetch_cnt_q;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dlx_fetch_unit.sv
module tb_dlx_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] inst_o, pc_o, npc_o, fetch_cnt_o;
  logic        valid_o, halted_o;

  logic [31:0] rom [64];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fetch-stage behaviour described in terms of the
  // program counter and what the decode stage should be looking at.
  logic [31:0] m_pc, m_inst, m_pco, m_npc, m_cnt;
  logic        m_valid, m_booting, m_halted;

  always #5 clk = ~clk;

  assign rom_data_i = rom[rom_addr_o[5:0]];

  dlx_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .npc_o         (npc_o),
    .valid_o       (valid_o),
    .halted_o      (halted_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  function automatic logic [193:0] act();
    return {inst_o, pc_o, npc_o, valid_o, halted_o, rom_addr_o, fetch_cnt_o};
  endfunction

  function automatic logic [193:0] exp();
    logic [31:0] c;
`ifdef FETCH_PERF_CNT_EN
    c = m_cnt;
`else
    c = 32'd0;
`endif
    return {m_inst, m_pco, m_npc, m_valid, m_halted, {26'd0, m_pc[7:2]}, c};
  endfunction

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] rpc);
    logic [31:0] w;
    rst_i = rst; stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
    w = rom[m_pc[7:2]];
    if (rst) begin
      m_pc = 32'd0; m_booting = 1'b1; m_halted = 1'b0;
      m_inst = NOP; m_pco = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      if (!stall) begin m_inst = NOP; m_valid = 1'b0; end
    end else if (redir) begin
      m_pc = {rpc[31:2], 2'b00}; m_inst = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_inst = w; m_pco = m_pc; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
      if (w == HLT) m_halted = 1'b1;
      else          m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if (rom[i] == HLT) rom[i] = 32'h1234_5678;
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    n_cmp++;
    if (act() !== exp() || inst_o !== NOP || valid_o !== 1'b0 || fetch_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL reset got=%h want=%h", act(), exp());
    end
  endtask

  task automatic test_sequential();
    step(1, 0, 0, 0);
    step(0, 1, 1, 32'h80);  // BOOT ignores stall/redirect
    n_cmp++;
    if (act() !== exp() || valid_o !== 1'b0 || rom_addr_o !== 32'd0) begin
      n_bad++; $display("FAIL boot got=%h want=%h", act(), exp());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_cmp++;
      if (act() !== exp() || inst_o !== rom[i] || pc_o !== 4*i || npc_o !== 4*i+4
          || rom_addr_o !== i+1) begin
        n_bad++; $display("FAIL seq%0d got=%h want=%h", i, act(), exp());
      end
    end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      n_cmp++;
      if (act() !== exp() || rom_addr_o !== 32'd2 || pc_o !== 32'd4 || inst_o !== rom[1]) begin
        n_bad++; $display("FAIL stall%0d got=%h want=%h", i, act(), exp());
      end
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || inst_o !== rom[2] || pc_o !== 32'd8) begin
      n_bad++; $display("FAIL stall_release got=%h want=%h", act(), exp());
    end
  endtask

  task automatic test_redirect();
    step(0, 1, 1, 32'h0000_0013);
    n_cmp++;
    if (act() !== exp() || valid_o !== 1'b0 || inst_o !== NOP || rom_addr_o !== 32'd4) begin
      n_bad++; $display("FAIL redirect got=%h want=%h", act(), exp());
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || inst_o !== rom[4] || pc_o !== 32'd16) begin
      n_bad++; $display("FAIL redirect_fetch got=%h want=%h", act(), exp());
    end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    saved = rom[5];
    rom[5] = HLT;
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || inst_o !== HLT || valid_o !== 1'b1 || halted_o !== 1'b1
        || rom_addr_o !== 32'd5) begin
      n_bad++; $display("FAIL halt_capture got=%h want=%h", act(), exp());
    end
    step(0, 1, 0, 0);
    n_cmp++;
    if (act() !== exp() || valid_o !== 1'b1) begin
      n_bad++; $display("FAIL halt_stall got=%h want=%h", act(), exp());
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || valid_o !== 1'b0 || inst_o !== NOP) begin
      n_bad++; $display("FAIL halt_clear got=%h want=%h", act(), exp());
    end
    step(0, 0, 1, 32'h0000_0100);
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || rom_addr_o !== 32'd5 || halted_o !== 1'b1) begin
      n_bad++; $display("FAIL halt_redirect got=%h want=%h", act(), exp());
    end
    rom[5] = saved;
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'd252);
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || pc_o !== 32'd252 || inst_o !== rom[63] || rom_addr_o !== 32'd0) begin
      n_bad++; $display("FAIL wrap_edge got=%h want=%h", act(), exp());
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || pc_o !== 32'd256 || npc_o !== 32'd260 || inst_o !== rom[0]) begin
      n_bad++; $display("FAIL wrap_next got=%h want=%h", act(), exp());
    end
  endtask

  task automatic test_counter();
    logic [31:0] want;
`ifdef FETCH_PERF_CNT_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || fetch_cnt_o !== want) begin
      n_bad++; $display("FAIL counter got=%0d want=%0d", fetch_cnt_o, want);
    end
    step(1, 0, 0, 0);
    n_cmp++;
    if (act() !== exp() || fetch_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL counter_reset got=%0d want=0", fetch_cnt_o);
    end
  endtask

  task automatic test_random();
    logic r, s, d;
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rom[$urandom_range(0, 63)] = HLT;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0);
      step(r, s, d, $urandom);
      n_cmp++;
      if (act() !== exp()) begin
        n_bad++; $display("FAIL random%0d got=%h want=%h", i, act(), exp());
      end
      if (m_halted && $urandom_range(0, 7) == 0) begin
        fill_rom();
        step(1, 0, 0, 0);
      end
    end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
